// File: rtl/fixed_point_square_pkg.sv
// Shared constants and state type for the shift-add squarer.
package fixed_point_square_pkg;

  localparam int unsigned SR_FIXED_POINT_BITS = 16;
  localparam int unsigned FIXED_POINT_BITS    = 4;
  localparam int unsigned SQ_ROUND_SHIFT      = 2 * SR_FIXED_POINT_BITS - FIXED_POINT_BITS;

  typedef enum logic [1:0] {
    SQ_IDLE  = 2'd0,
    SQ_MUL   = 2'd1,
    SQ_ROUND = 2'd2,
    SQ_DONE  = 2'd3
  } sq_state_t;

endpackage

// File: rtl/fixed_point_square_if.sv
// Start/result handshake bundle shared with the square-root unit.
interface fixed_point_square_if #(
  parameter int unsigned W_IN  = 24,
  parameter int unsigned W_OUT = 12
);
  logic             start;
  logic [W_IN-1:0]  X;
  logic             busy;
  logic             valid;
  logic [W_OUT-1:0] Y;
  logic             sat;

  modport master (output start, output X, input busy, input valid, input Y, input sat);
  modport slave  (input start, input X, output busy, output valid, output Y, output sat);
endinterface

// File: rtl/fixed_point_square.sv
// Sequential shift-add squarer: Y = round(X^2 * 2^(OUT_FRAC - 2*IN_FRAC)), saturated.
// Optional SQ_EARLY_EXIT_EN: leave MUL once the remaining multiplier is zero.
module fixed_point_square
  import fixed_point_square_pkg::*;
#(
  parameter int unsigned W_IN     = 24,
  parameter int unsigned IN_FRAC  = SR_FIXED_POINT_BITS,
  parameter int unsigned W_OUT    = 12,
  parameter int unsigned OUT_FRAC = FIXED_POINT_BITS
) (
  input logic                  clk,
  input logic                  rst_,
  fixed_point_square_if.slave  bus
);

  localparam int unsigned W_ACC = 2 * W_IN;
  localparam int unsigned S     = 2 * IN_FRAC - OUT_FRAC;
  localparam int unsigned K_W   = $clog2(W_IN);
  localparam logic [K_W-1:0]   K_LAST = K_W'(W_IN - 1);
  localparam logic [W_ACC:0]   HALF   = (W_ACC + 1)'(1) << (S - 1);

  sq_state_t         state_q, state_d;
  logic [W_IN-1:0]   mcand_q, mcand_d;
  logic [W_IN-1:0]   mplier_q, mplier_d;
  logic [W_ACC-1:0]  acc_q, acc_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [W_OUT-1:0]  y_q, y_d;
  logic              sat_q, sat_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [W_ACC:0]    rnd;
  logic [W_ACC:0]    rsh;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    k_d      = k_q;
    y_d      = y_q;
    sat_d    = sat_q;
    rnd      = {1'b0, acc_q} + HALF;
    rsh      = rnd >> S;

    unique case (state_q)
      SQ_IDLE: begin
        if (bus.start) begin
          mcand_d  = bus.X;
          mplier_d = bus.X;
          acc_d    = '0;
          k_d      = '0;
          state_d  = SQ_MUL;
        end
      end
      SQ_MUL: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + ({{W_IN{1'b0}}, mcand_q} << k_q);
        end
        mplier_d = mplier_q >> 1;
        k_d      = k_q + 1'b1;
`ifdef SQ_EARLY_EXIT_EN
        if (mplier_d == '0 || k_q == K_LAST) begin
          state_d = SQ_ROUND;
        end
`else
        if (k_q == K_LAST) begin
          state_d = SQ_ROUND;
        end
`endif
      end
      SQ_ROUND: begin
        // Any bit above the output width after the rounding shift means overflow.
        if (|rsh[W_ACC:W_OUT]) begin
          y_d   = '1;
          sat_d = 1'b1;
        end else begin
          y_d   = rsh[W_OUT-1:0];
          sat_d = 1'b0;
        end
        state_d = SQ_DONE;
      end
      SQ_DONE: begin
        state_d = SQ_IDLE;
      end
      default: state_d = SQ_IDLE;
    endcase

    busy_d  = (state_d == SQ_MUL) || (state_d == SQ_ROUND);
    valid_d = (state_d == SQ_DONE);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q  <= SQ_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      k_q      <= '0;
      y_q      <= '0;
      sat_q    <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      k_q      <= k_d;
      y_q      <= y_d;
      sat_q    <= sat_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.valid = valid_q;
  assign bus.Y     = y_q;
  assign bus.sat   = sat_q;

endmodule

// File: tb/tb_fixed_point_square.sv
// Directed-vector bench for fixed_point_square (fixed and early-exit builds).
module tb_fixed_point_square;

  logic clk = 1'b0;
  logic rst_ = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fixed_point_square_if #(.W_IN(24), .W_OUT(12)) bus();

  fixed_point_square #(
    .W_IN(24), .IN_FRAC(16), .W_OUT(12), .OUT_FRAC(4)
  ) dut (
    .clk (clk),
    .rst_(rst_),
    .bus (bus.slave)
  );

  typedef struct {
    logic [23:0] x;
    logic [11:0] y;
    logic        sat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [23:0] x);
`ifdef SQ_EARLY_EXIT_EN
    int it = 1;
    for (int b = 0; b < 24; b++) if (x[b]) it = b + 1;
    return it + 1;
`else
    return 25;
`endif
  endfunction

  task automatic run_op(input logic [23:0] x, output int lat, output logic [11:0] y,
                        output logic s, output logic busy_ok);
    @(negedge clk);
    bus.start = 1'b1;
    bus.X     = x;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.X     = '0;
    busy_ok = bus.busy;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus.valid) begin
        lat = i;
        if (bus.busy) busy_ok = 1'b0;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
    end
    y = bus.Y;
    s = bus.sat;
  endtask

  task automatic op_and_check(input string name, input logic [23:0] x,
                              input logic [11:0] ey, input logic es);
    int lat; logic [11:0] y; logic s; logic bok;
    run_op(x, lat, y, s, bok);
    chk({name, ".lat"}, lat, exp_lat(x));
    chk({name, ".Y"}, {20'd0, y}, {20'd0, ey});
    chk({name, ".sat"}, {31'd0, s}, {31'd0, es});
    chk({name, ".busy"}, {31'd0, bok}, 32'd1);
    @(posedge clk); #1;
    chk({name, ".valid_pulse"}, {31'd0, bus.valid}, 32'd0);
    chk({name, ".Y_hold"}, {20'd0, bus.Y}, {20'd0, ey});
  endtask

  initial begin
    vec_t vecs[$];
    int   nvalid;

    vecs.push_back('{24'h020000, 12'h040, 1'b0});
    vecs.push_back('{24'h018000, 12'h024, 1'b0});
    vecs.push_back('{24'h0F0000, 12'hE10, 1'b0});
    vecs.push_back('{24'h005A82, 12'h002, 1'b0});
    vecs.push_back('{24'h002000, 12'h000, 1'b0});
    vecs.push_back('{24'h000000, 12'h000, 1'b0});
    vecs.push_back('{24'h000001, 12'h000, 1'b0});
    vecs.push_back('{24'h100000, 12'hFFF, 1'b1});
    vecs.push_back('{24'h0FFFFF, 12'hFFF, 1'b1});
    vecs.push_back('{24'hFFFFFF, 12'hFFF, 1'b1});
    vecs.push_back('{24'h010000, 12'h010, 1'b0});

    bus.start = 1'b0;
    bus.X     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy",  {31'd0, bus.busy},  32'd0);
    chk("reset.valid", {31'd0, bus.valid}, 32'd0);
    chk("reset.Y",     {20'd0, bus.Y},     32'd0);
    chk("reset.sat",   {31'd0, bus.sat},   32'd0);
    @(negedge clk);
    rst_ = 1'b1;

    foreach (vecs[i]) begin
      op_and_check($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].sat);
    end

    // Asynchronous reset in the middle of MUL, with a nonzero result held.
    @(negedge clk);
    bus.start = 1'b1;
    bus.X     = 24'h0F0000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst.busy_before", {31'd0, bus.busy}, 32'd1);
    rst_ = 1'b0;
    #1;
    chk("midrst.busy",  {31'd0, bus.busy},  32'd0);
    chk("midrst.valid", {31'd0, bus.valid}, 32'd0);
    chk("midrst.Y",     {20'd0, bus.Y},     32'd0);
    chk("midrst.sat",   {31'd0, bus.sat},   32'd0);
    @(negedge clk);
    rst_ = 1'b1;
    op_and_check("after_rst", 24'h018000, 12'h024, 1'b0);

    // start held high while busy must yield exactly one result.
    @(negedge clk);
    bus.start = 1'b1;
    bus.X     = 24'h010000;
    nvalid = 0;
    for (int i = 0; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 15) bus.start = 1'b0;
      if (bus.valid) nvalid++;
    end
    chk("hold_start.nvalid", nvalid, 32'd1);
    chk("hold_start.Y", {20'd0, bus.Y}, 32'h010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
